// File: rtl/pixel_region_readout_ctrl_if.sv
// rtl/pixel_region_readout_ctrl_if.sv - trigger, region and output-stream bundle for the region readout controller
// slave = controller side, master = trigger source / regions / stream sink side.

interface pixel_region_readout_ctrl_if #(
    parameter int NREG      = 4,
    parameter int DATA_BITS = 16
);
    logic                      TrigValid;
    logic [4:0]                TrigId;
    logic                      TrigReady;
    logic [4:0]                L1Req;
    logic [NREG-1:0]           RegReq;
    logic [NREG*DATA_BITS-1:0] RegData;
    logic [NREG-1:0]           ReadData;
    logic                      OutValid;
    logic                      OutReady;
    logic [DATA_BITS-1:0]      OutData;
    logic                      OutEoe;
    logic [4:0]                OutTrigId;
    logic                      Busy;
    logic                      TqFull;

    modport slave (
        input  TrigValid, TrigId, RegReq, RegData, OutReady,
        output TrigReady, L1Req, ReadData, OutValid, OutData, OutEoe, OutTrigId, Busy, TqFull
    );

    modport master (
        output TrigValid, TrigId, RegReq, RegData, OutReady,
        input  TrigReady, L1Req, ReadData, OutValid, OutData, OutEoe, OutTrigId, Busy, TqFull
    );
endinterface

// File: rtl/pixel_region_readout_ctrl.sv
// rtl/pixel_region_readout_ctrl.sv - trigger-queued readout of pixel-region latency memories into one output stream
// Optional macro CBA_READOUT_RR_EN: round-robin region selection; default is fixed lowest-index priority.

module pixel_region_readout_ctrl #(
    parameter int NREG      = 4,
    parameter int DATA_BITS = 16,
    parameter int TQ_DEPTH  = 4
) (
    input  logic                        Clk,
    input  logic                        ResetB,
    pixel_region_readout_ctrl_if.slave  bus
);
    localparam int KW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int QW = (TQ_DEPTH > 1) ? $clog2(TQ_DEPTH) : 1;
    localparam int CW = $clog2(TQ_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SCAN   = 3'd2,
        READ   = 3'd3,
        OUT    = 3'd4,
        EOE    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           settle_q, settle_d;
    logic [KW-1:0]        k_q, k_d;
    logic [4:0]           l1_req_q, l1_req_d;
    logic [4:0]           out_trig_id_q, out_trig_id_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_eoe_q, out_eoe_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;
    logic [QW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [QW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [4:0]           tq_q [TQ_DEPTH];
`ifdef CBA_READOUT_RR_EN
    logic [KW-1:0]        rr_ptr_q, rr_ptr_d;
    int                   rr_idx;
`endif

    logic                 trig_ready;
    logic                 push;
    logic                 pop;
    logic                 found;
    logic [KW-1:0]        sel;
    logic [NREG-1:0]      read_onehot;
    logic [DATA_BITS-1:0] reg_data_sel;

    // No pass-through: a full queue refuses the push even if IDLE pops the same cycle.
    assign trig_ready   = (count_q < CW'(TQ_DEPTH));
    assign push         = bus.TrigValid && trig_ready;
    assign pop          = (state_q == IDLE) && (count_q != '0);
    assign reg_data_sel = bus.RegData[int'(k_q)*DATA_BITS +: DATA_BITS];

    always_comb begin
        found = 1'b0;
        sel   = '0;
`ifdef CBA_READOUT_RR_EN
        rr_idx = 0;
        for (int i = 1; i <= NREG; i++) begin
            rr_idx = (int'(rr_ptr_q) + i) % NREG;
            if (!found && bus.RegReq[rr_idx]) begin
                found = 1'b1;
                sel   = KW'(rr_idx);
            end
        end
`else
        for (int i = 0; i < NREG; i++) begin
            if (!found && bus.RegReq[i]) begin
                found = 1'b1;
                sel   = KW'(i);
            end
        end
`endif
    end

    always_comb begin
        read_onehot = '0;
        if (state_q == READ) begin
            read_onehot[k_q] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        k_d           = k_q;
        l1_req_d      = l1_req_q;
        out_trig_id_d = out_trig_id_q;
        out_valid_d   = out_valid_q;
        out_eoe_d     = out_eoe_q;
        out_data_d    = out_data_q;
        wr_ptr_d      = wr_ptr_q + QW'(push);
        rd_ptr_d      = rd_ptr_q + QW'(pop);
        count_d       = count_q + CW'(push) - CW'(pop);
`ifdef CBA_READOUT_RR_EN
        rr_ptr_d      = rr_ptr_q;
`endif

        case (state_q)
            IDLE: begin
                if (pop) begin
                    l1_req_d      = tq_q[rd_ptr_q];
                    out_trig_id_d = tq_q[rd_ptr_q];
                    settle_d      = 2'd2;
                    state_d       = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == 2'd1) begin
                    state_d = SCAN;
                end else begin
                    settle_d = settle_q - 2'd1;
                end
            end
            SCAN: begin
                if (found) begin
                    k_d     = sel;
`ifdef CBA_READOUT_RR_EN
                    rr_ptr_d = sel;
`endif
                    state_d = READ;
                end else begin
                    out_valid_d = 1'b1;
                    out_eoe_d   = 1'b1;
                    out_data_d  = '0;
                    state_d     = EOE;
                end
            end
            READ: begin
                out_data_d  = reg_data_sel;
                out_valid_d = 1'b1;
                out_eoe_d   = 1'b0;
                state_d     = OUT;
            end
            OUT: begin
                // One settle cycle lets the popped region drop its request before rescanning.
                if (bus.OutReady) begin
                    out_valid_d = 1'b0;
                    settle_d    = 2'd1;
                    state_d     = SETTLE;
                end
            end
            EOE: begin
                if (bus.OutReady) begin
                    out_valid_d = 1'b0;
                    out_eoe_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge ResetB) begin
        if (!ResetB) begin
            state_q       <= IDLE;
            settle_q      <= '0;
            k_q           <= '0;
            l1_req_q      <= '0;
            out_trig_id_q <= '0;
            out_valid_q   <= 1'b0;
            out_eoe_q     <= 1'b0;
            out_data_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
`ifdef CBA_READOUT_RR_EN
            rr_ptr_q      <= KW'(NREG - 1);
`endif
            for (int i = 0; i < TQ_DEPTH; i++) begin
                tq_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            k_q           <= k_d;
            l1_req_q      <= l1_req_d;
            out_trig_id_q <= out_trig_id_d;
            out_valid_q   <= out_valid_d;
            out_eoe_q     <= out_eoe_d;
            out_data_q    <= out_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
`ifdef CBA_READOUT_RR_EN
            rr_ptr_q      <= rr_ptr_d;
`endif
            if (push) begin
                tq_q[wr_ptr_q] <= bus.TrigId;
            end
        end
    end

    assign bus.TrigReady = trig_ready;
    assign bus.TqFull    = (count_q == CW'(TQ_DEPTH));
    assign bus.Busy      = (state_q != IDLE);
    assign bus.L1Req     = l1_req_q;
    assign bus.ReadData  = read_onehot;
    assign bus.OutValid  = out_valid_q;
    assign bus.OutData   = out_data_q;
    assign bus.OutEoe    = out_eoe_q;
    assign bus.OutTrigId = out_trig_id_q;

endmodule

// File: tb/tb_pixel_region_readout_ctrl.sv
// tb/tb_pixel_region_readout_ctrl.sv - directed and randomized bench for pixel_region_readout_ctrl
// Regions are modelled as data queues; expected stream order is derived from per-trigger hit counts.

module tb_pixel_region_readout_ctrl;
    localparam int NREG = 4;
    localparam int DB   = 16;

    typedef struct packed {
        logic [4:0]            id;
        logic [NREG-1:0][1:0]  cnt;
    } plan_t;

    typedef struct packed {
        logic          eoe;
        logic [DB-1:0] data;
        logic [4:0]    tid;
    } word_t;

    logic Clk = 1'b0;
    logic ResetB;

    pixel_region_readout_ctrl_if #(.NREG(NREG), .DATA_BITS(DB)) bus();

    pixel_region_readout_ctrl #(.NREG(NREG), .DATA_BITS(DB), .TQ_DEPTH(4)) dut (
        .Clk    (Clk),
        .ResetB (ResetB),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    int           n_cmp = 0;
    int           n_err = 0;
    plan_t        model_q[$];
    word_t        exp_words[$];
    int           exp_regions[$];
    logic [DB-1:0] reg_q[NREG][$];
    logic [NREG-1:0] served[$];
    plan_t        cur_plan;
    int           pend_pop = -1;
    int           rr_m = NREG - 1;
    int           push_count = 0;
    logic         prev_busy = 1'b0;
    logic         prev_hold = 1'b0;
    logic [DB-1:0] prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_regions();
        for (int r = 0; r < NREG; r++) begin
            bus.RegReq[r] = (reg_q[r].size() > 0);
            bus.RegData[r*DB +: DB] = (reg_q[r].size() > 0) ? reg_q[r][0] : '0;
        end
    endtask

    task automatic build_expect(input plan_t p);
        int rem[NREG];
        int tk[NREG];
        int total;
        total = 0;
        for (int r = 0; r < NREG; r++) begin
            for (int j = 0; j < int'(p.cnt[r]); j++) reg_q[r].push_back(DB'($urandom));
            rem[r] = int'(p.cnt[r]);
            tk[r]  = 0;
            total += rem[r];
        end
`ifdef CBA_READOUT_RR_EN
        while (total > 0) begin
            for (int i = 1; i <= NREG; i++) begin
                int r;
                r = (rr_m + i) % NREG;
                if (rem[r] > 0) begin
                    exp_regions.push_back(r);
                    exp_words.push_back({1'b0, reg_q[r][tk[r]], p.id});
                    rem[r]--; tk[r]++; total--;
                    rr_m = r;
                    break;
                end
            end
        end
`else
        for (int r = 0; r < NREG; r++) begin
            for (int j = 0; j < rem[r]; j++) begin
                exp_regions.push_back(r);
                exp_words.push_back({1'b0, reg_q[r][j], p.id});
            end
        end
`endif
        exp_words.push_back({1'b1, {DB{1'b0}}, p.id});
    endtask

    // Inputs set since the previous sample are what the coming edge sees.
    task automatic tick();
        word_t w;
        plan_t p;
        int    r;
        if (bus.TrigValid && bus.TrigReady) begin
            model_q.push_back(cur_plan);
            push_count++;
        end
        if (bus.OutValid && bus.OutReady) begin
            if (exp_words.size() == 0) begin
                check("unexpected_word", 32'(bus.OutValid), 32'd0);
            end else begin
                w = exp_words.pop_front();
                check("word_eoe", 32'(bus.OutEoe), 32'(w.eoe));
                check("word_data", 32'(bus.OutData), 32'(w.data));
                check("word_tid", 32'(bus.OutTrigId), 32'(w.tid));
            end
        end
        prev_hold = bus.OutValid && !bus.OutReady;
        prev_data = bus.OutData;
        @(posedge Clk);
        #1;
        if (pend_pop >= 0) begin
            void'(reg_q[pend_pop].pop_front());
            pend_pop = -1;
        end
        if (bus.Busy && !prev_busy) begin
            if (model_q.size() == 0) begin
                check("pop_unexpected", 32'(bus.Busy), 32'd0);
            end else begin
                p = model_q.pop_front();
                check("pop_l1req", 32'(bus.L1Req), 32'(p.id));
                check("pop_outtrigid", 32'(bus.OutTrigId), 32'(p.id));
                build_expect(p);
            end
        end
        prev_busy = bus.Busy;
        drive_regions();
        check("trig_ready", 32'(bus.TrigReady), 32'(model_q.size() < 4));
        check("tq_full", 32'(bus.TqFull), 32'(model_q.size() == 4));
        if (bus.ReadData != '0) begin
            served.push_back(bus.ReadData);
            check("readdata_onehot", 32'($onehot(bus.ReadData)), 32'd1);
            if (exp_regions.size() == 0) begin
                check("readdata_unexpected", 32'(bus.ReadData), 32'd0);
            end else begin
                r = exp_regions.pop_front();
                check("readdata_region", 32'(bus.ReadData), 32'(1) << r);
                pend_pop = r;
            end
        end
        if (prev_hold) begin
            check("hold_valid", 32'(bus.OutValid), 32'd1);
            check("hold_data", 32'(bus.OutData), 32'(prev_data));
        end
    endtask

    task automatic run_idle(input int bound, input bit rand_ready);
        int n;
        n = 0;
        bus.TrigValid = 1'b0;
        while ((model_q.size() != 0 || exp_words.size() != 0 || bus.Busy) && n < bound) begin
            bus.OutReady = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            n++;
        end
        check("drain_done", 32'(n < bound), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_outvalid"}, 32'(bus.OutValid), 32'd0);
        check({tag, "_outeoe"}, 32'(bus.OutEoe), 32'd0);
        check({tag, "_outdata"}, 32'(bus.OutData), 32'd0);
        check({tag, "_outtrigid"}, 32'(bus.OutTrigId), 32'd0);
        check({tag, "_l1req"}, 32'(bus.L1Req), 32'd0);
        check({tag, "_readdata"}, 32'(bus.ReadData), 32'd0);
        check({tag, "_busy"}, 32'(bus.Busy), 32'd0);
        check({tag, "_tqfull"}, 32'(bus.TqFull), 32'd0);
        check({tag, "_trigready"}, 32'(bus.TrigReady), 32'd1);
    endtask

    task automatic clear_model();
        model_q.delete();
        exp_words.delete();
        exp_regions.delete();
        for (int r = 0; r < NREG; r++) reg_q[r].delete();
        pend_pop  = -1;
        rr_m      = NREG - 1;
        prev_busy = 1'b0;
        prev_hold = 1'b0;
        drive_regions();
    endtask

    function automatic plan_t mk_plan(input logic [4:0] id, input int c0, input int c1, input int c2, input int c3);
        plan_t p;
        p.id     = id;
        p.cnt[0] = 2'(c0);
        p.cnt[1] = 2'(c1);
        p.cnt[2] = 2'(c2);
        p.cnt[3] = 2'(c3);
        return p;
    endfunction

    initial begin
        int n;
        ResetB        = 1'b0;
        bus.TrigValid = 1'b0;
        bus.TrigId    = '0;
        bus.OutReady  = 1'b0;
        cur_plan      = '0;
        prev_data     = '0;
        clear_model();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge Clk);
        #1;
        ResetB = 1'b1;
        tick();

        // Empty event: only the EOE word, no region pop.
        bus.OutReady  = 1'b1;
        bus.TrigValid = 1'b1;
        bus.TrigId    = 5'd5;
        cur_plan      = mk_plan(5'd5, 0, 0, 0, 0);
        served.delete();
        tick();
        bus.TrigValid = 1'b0;
        tick();
        check("e1_busy", 32'(bus.Busy), 32'd1);
        check("e1_l1req", 32'(bus.L1Req), 32'd5);
        tick(); tick();
        check("e3_outvalid", 32'(bus.OutValid), 32'd0);
        tick();
        check("e4_eoe_valid", 32'(bus.OutValid), 32'd1);
        check("e4_eoe_flag", 32'(bus.OutEoe), 32'd1);
        run_idle(200, 1'b0);
        check("empty_no_readdata", 32'(served.size()), 32'd0);
        check("empty_l1req_held", 32'(bus.L1Req), 32'd5);

        // Regions 1 and 3, one hit each: exact latency of the first pop.
        bus.TrigValid = 1'b1;
        bus.TrigId    = 5'd3;
        cur_plan      = mk_plan(5'd3, 0, 1, 0, 1);
        served.delete();
        tick();
        bus.TrigValid = 1'b0;
        tick(); tick(); tick();
        check("e3_readdata_zero", 32'(bus.ReadData), 32'd0);
        tick();
        check("e4_readdata", 32'(bus.ReadData), 32'b0010);
        tick();
        check("e5_outvalid", 32'(bus.OutValid), 32'd1);
        run_idle(200, 1'b0);
        check("two_pops", 32'(served.size()), 32'd2);
        if (served.size() == 2) check("second_pop", 32'(served[1]), 32'b1000);

        // Two requesters held across two pops: arbitration policy.
        bus.TrigValid = 1'b1;
        bus.TrigId    = 5'd7;
        cur_plan      = mk_plan(5'd7, 2, 2, 0, 0);
        served.delete();
        tick();
        bus.TrigValid = 1'b0;
        run_idle(300, 1'b0);
        check("arb_pops", 32'(served.size()), 32'd4);
        if (served.size() >= 2) begin
            check("arb_first", 32'(served[0]), 32'b0001);
`ifdef CBA_READOUT_RR_EN
            check("arb_second", 32'(served[1]), 32'b0010);
`else
            check("arb_second", 32'(served[1]), 32'b0001);
`endif
        end

        // Stall in OUT, fill the queue behind it, then release.
        bus.OutReady  = 1'b0;
        bus.TrigValid = 1'b1;
        bus.TrigId    = 5'd1;
        cur_plan      = mk_plan(5'd1, 0, 0, 1, 0);
        tick();
        bus.TrigValid = 1'b0;
        n = 0;
        while (!bus.OutValid && n < 50) begin tick(); n++; end
        check("stall_reached_out", 32'(bus.OutValid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.TrigValid = 1'b1;
            bus.TrigId    = 5'(20 + i);
            cur_plan      = mk_plan(5'(20 + i), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            tick();
        end
        check("full_tqfull", 32'(bus.TqFull), 32'd1);
        check("full_trigready", 32'(bus.TrigReady), 32'd0);
        bus.TrigId = 5'd24;
        cur_plan   = mk_plan(5'd24, 1, 0, 0, 1);
        served.delete();
        n = push_count;
        repeat (10) tick();
        check("stall_no_push", 32'(push_count), 32'(n));
        check("stall_no_readdata", 32'(served.size()), 32'd0);
        check("stall_valid", 32'(bus.OutValid), 32'd1);
        bus.OutReady = 1'b1;
        n = 0;
        while (push_count == 4 + 1 + 3 && n < 500) begin tick(); n++; end
        check("fifth_accepted", 32'(n < 500), 32'd1);
        run_idle(2000, 1'b1);

        // Randomized traffic.
        for (int c = 0; c < 700; c++) begin
            bus.OutReady  = ($urandom_range(0, 3) != 0);
            bus.TrigValid = ($urandom_range(0, 2) == 0);
            bus.TrigId    = 5'($urandom);
            cur_plan      = mk_plan(bus.TrigId, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            tick();
        end
        run_idle(5000, 1'b1);

        // Reset during READ discards queue and pending word.
        bus.OutReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.TrigValid = 1'b1;
            bus.TrigId    = 5'(9 + i);
            cur_plan      = mk_plan(5'(9 + i), 1, 1, 1, 1);
            tick();
        end
        bus.TrigValid = 1'b0;
        n = 0;
        while (bus.ReadData == '0 && n < 100) begin tick(); n++; end
        check("reached_read", 32'(bus.ReadData != '0), 32'd1);
        ResetB = 1'b0;
        #1;
        check_reset_outputs("midreset");
        clear_model();
        tick(); tick();
        check("reset_held_readdata", 32'(bus.ReadData), 32'd0);
        ResetB = 1'b1;
        repeat (6) tick();
        check("post_reset_busy", 32'(bus.Busy), 32'd0);
        check("post_reset_outvalid", 32'(bus.OutValid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
